// File: rtl/bldc_sixstep_driver_pkg.sv
// Shared encodings for the six-step BLDC driver: Hall code, direction, driver state, PWM mode.
// Also holds the forward commutation table so every consumer decodes Hall codes identically.
package bldc_sixstep_driver_pkg;

  typedef logic [2:0] hall_states_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2,
    DIR_RSVD = 2'd3
  } rotation_direction_t;

  typedef enum logic [1:0] {
    PWM_HI     = 2'd0,
    PWM_LO     = 2'd1,
    PWM_BOTH   = 2'd2,
    PWM_HI_ALT = 2'd3
  } pwm_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_REVERSE    = 3'd2,
    ST_ERROR      = 3'd3,
    ST_GATE_RESET = 3'd4,
    ST_LOCKOUT    = 3'd6
  } driver_state_t;

  function automatic logic hall_invalid(input hall_states_t h);
    return (h == 3'b000) || (h == 3'b111);
  endfunction

  // {A+,B+,C+,A-,B-,C-}; invalid codes leave every switch open.
  function automatic logic [5:0] fwd_pattern(input hall_states_t h);
    logic [5:0] p;
    case (h)
      3'b101:  p = 6'b100_010;
      3'b100:  p = 6'b100_001;
      3'b110:  p = 6'b010_001;
      3'b010:  p = 6'b010_100;
      3'b011:  p = 6'b001_100;
      3'b001:  p = 6'b001_010;
      default: p = 6'b000_000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bldc_sixstep_driver_duty_slew_limiter.sv
// Wrap-timed duty ramp: moves duty toward target by at most ramp_step per step_en pulse.
// Latency: 1 cycle from step_en, clear forces zero; no backpressure.
module duty_slew_limiter
  import bldc_sixstep_driver_pkg::*;
#(
  parameter int duty_width = 12,
  parameter int ramp_step  = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  step_en,
  input  logic [duty_width-1:0] duty_target,
  output logic [duty_width-1:0] duty_next,
  output logic [duty_width-1:0] duty_actual
);

  localparam logic [duty_width-1:0] STEP = duty_width'(ramp_step);

  logic [duty_width-1:0] gap;

  // Saturate on the remaining gap so the ramp lands exactly on the target.
  always_comb begin
    gap       = '0;
    duty_next = duty_actual;
    if (duty_target > duty_actual) begin
      gap       = duty_target - duty_actual;
      duty_next = duty_actual + ((gap > STEP) ? STEP : gap);
    end else if (duty_target < duty_actual) begin
      gap       = duty_actual - duty_target;
      duty_next = duty_actual - ((gap > STEP) ? STEP : gap);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_actual <= '0;
    end else if (clear) begin
      duty_actual <= '0;
    end else if (step_en) begin
      duty_actual <= duty_next;
    end
  end

endmodule

// File: rtl/bldc_sixstep_driver.sv
// Six-step BLDC driver with slewed PWM, reversal coast and gate-fault retry (BLDC_FAULT_RETRY_EN).
// Latency: Hall edge to gate outputs 3 cycles, state exits 1 cycle; no backpressure.
module bldc_sixstep_driver
  import bldc_sixstep_driver_pkg::*;
#(
  parameter int unsigned clk_freq_hz     = 54_000_000,
  parameter int unsigned pwm_freq_hz     = 20_000,
  parameter int          duty_width      = 12,
  parameter int          ramp_step       = 8,
  parameter int unsigned reverse_wait_ms = 50,
  parameter int unsigned gate_reset_us   = 100,
  parameter int          fault_retry_max = 3
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  hall_states_t          hall_values,
  input  logic                  invert_phases,
  input  logic                  enable,
  input  rotation_direction_t   direction,
  input  logic [duty_width-1:0] duty_target,
  input  logic [1:0]            pwm_mode,
  input  logic                  fault_n,
  input  logic                  clear_lockout,
  output logic [5:0]            phase_enable,
  output logic [5:0]            pwm_out,
  output logic                  gate_enable,
  output logic [duty_width-1:0] duty_actual,
  output logic [2:0]            driver_state,
  output logic [1:0]            retry_count,
  output logic                  lockout
);

  localparam int unsigned     PERIOD  = clk_freq_hz / pwm_freq_hz;
  localparam int              CW      = $clog2(PERIOD);
  localparam int              PW      = duty_width + CW;
  localparam longint unsigned REV_CYC = (64'(clk_freq_hz) * 64'(reverse_wait_ms)) / 64'd1000;
  localparam longint unsigned GR_CYC  = (64'(clk_freq_hz) * 64'(gate_reset_us)) / 64'd1000000;
  localparam longint unsigned T_MAX   = (REV_CYC > GR_CYC) ? REV_CYC : GR_CYC;
  localparam int              TW      = $clog2(T_MAX + 64'd1);

  hall_states_t        hall_meta, hall_sync;
  logic                hall_error;
  driver_state_t       state, state_nxt;
  rotation_direction_t dir_q, dir_nxt;
  logic [1:0]          retry_q, retry_nxt;
  logic [TW-1:0]       tmr, tmr_nxt;
  logic                rev_done, gr_done, run_ok;
  logic [CW-1:0]       pwm_cnt, cmp_q, cmp_nxt;
  logic                pwm_wrap, full_q, pwm_raw;
  logic                slew_clear, slew_step;
  logic [duty_width-1:0] duty_next;
  logic                rev_sel;
  logic [5:0]          fwd, pattern;
  logic [2:0]          hi_g, lo_g;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_meta <= '0;
      hall_sync <= '0;
    end else begin
      hall_meta <= hall_values;
      hall_sync <= hall_meta;
    end
  end

  assign hall_error = hall_invalid(hall_sync);
  assign run_ok     = enable && (direction != DIR_NONE);
  assign rev_done   = (tmr == TW'(REV_CYC - 64'd1));
  assign gr_done    = (tmr == TW'(GR_CYC - 64'd1));

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    retry_nxt = retry_q;
    tmr_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (!enable) retry_nxt = '0;
        if (run_ok && !hall_error && fault_n) begin
          state_nxt = ST_RUN;
          dir_nxt   = direction;
        end
      end
      ST_RUN: begin
        if (hall_error) begin
          state_nxt = ST_ERROR;
        end else if (!fault_n) begin
`ifdef BLDC_FAULT_RETRY_EN
          state_nxt = ST_GATE_RESET;
          retry_nxt = retry_q + 2'd1;
`else
          state_nxt = ST_LOCKOUT;
`endif
        end else if (!run_ok) begin
          state_nxt = ST_IDLE;
        end else if (direction != dir_q) begin
          state_nxt = ST_REVERSE;
        end
      end
      ST_REVERSE: begin
        // Timer only counts time in the state; direction wobble does not restart it.
        tmr_nxt = tmr + TW'(1);
        if (rev_done) begin
          tmr_nxt   = '0;
          dir_nxt   = direction;
          state_nxt = run_ok ? ST_RUN : ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (!hall_error) state_nxt = ST_IDLE;
      end
      ST_GATE_RESET: begin
        tmr_nxt = tmr + TW'(1);
        if (gr_done) begin
          tmr_nxt = '0;
          if (fault_n)                            state_nxt = ST_IDLE;
          else if (retry_q == 2'(fault_retry_max)) state_nxt = ST_LOCKOUT;
          else                                    retry_nxt = retry_q + 2'd1;
        end
      end
      ST_LOCKOUT: begin
        if (clear_lockout) begin
          state_nxt = ST_IDLE;
          retry_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      dir_q   <= DIR_NONE;
      retry_q <= '0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      dir_q   <= dir_nxt;
      retry_q <= retry_nxt;
      tmr     <= tmr_nxt;
    end
  end

  // Duty is cleared in the same edge RUN is left, and stepped only on wraps inside RUN.
  assign pwm_wrap   = (pwm_cnt == CW'(PERIOD - 1));
  assign slew_clear = (state_nxt != ST_RUN);
  assign slew_step  = pwm_wrap && (state == ST_RUN);

  duty_slew_limiter #(
    .duty_width (duty_width),
    .ramp_step  (ramp_step)
  ) u_slew (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .clear       (slew_clear),
    .step_en     (slew_step),
    .duty_target (duty_target),
    .duty_next   (duty_next),
    .duty_actual (duty_actual)
  );

  assign cmp_nxt = CW'((PW'(duty_next) * PW'(PERIOD)) >> duty_width);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      cmp_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + CW'(1);
      if (slew_clear) begin
        cmp_q  <= '0;
        full_q <= 1'b0;
      end else if (slew_step) begin
        cmp_q  <= cmp_nxt;
        full_q <= &duty_next;
      end
    end
  end

  assign pwm_raw = full_q || (pwm_cnt < cmp_q);
  assign fwd     = fwd_pattern(hall_sync);
  assign rev_sel = (dir_nxt == DIR_REV) ^ invert_phases;
  assign pattern = (state_nxt != ST_RUN) ? 6'b0 :
                   (rev_sel ? {fwd[2:0], fwd[5:3]} : fwd);

  always_comb begin
    hi_g = pattern[5:3] & {3{pwm_raw}};
    lo_g = pattern[2:0];
    case (pwm_mode_t'(pwm_mode))
      PWM_LO: begin
        hi_g = pattern[5:3];
        lo_g = pattern[2:0] & {3{pwm_raw}};
      end
      PWM_BOTH: begin
        hi_g = pattern[5:3] & {3{pwm_raw}};
        lo_g = pattern[2:0] & {3{pwm_raw}};
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so they drop in the same edge as the exit.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_enable <= '0;
      pwm_out      <= '0;
      gate_enable  <= 1'b0;
      lockout      <= 1'b0;
    end else begin
      phase_enable <= pattern;
      pwm_out      <= {hi_g, lo_g};
      gate_enable  <= (state_nxt == ST_RUN);
      lockout      <= (state_nxt == ST_LOCKOUT);
    end
  end

  assign driver_state = state;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_bldc_sixstep_driver.sv
// Directed bench for bldc_sixstep_driver at 1 MHz / 10 kHz PWM (P=100), 8-bit duty, step 16.
`timescale 1ns/1ps
module tb_bldc_sixstep_driver;
  import bldc_sixstep_driver_pkg::*;

  logic                sys_clk = 1'b0;
  logic                reset_n;
  hall_states_t        hall_values;
  logic                invert_phases;
  logic                enable;
  rotation_direction_t direction;
  logic [7:0]          duty_target;
  logic [1:0]          pwm_mode;
  logic                fault_n;
  logic                clear_lockout;
  logic [5:0]          phase_enable;
  logic [5:0]          pwm_out;
  logic                gate_enable;
  logic [7:0]          duty_actual;
  logic [2:0]          driver_state;
  logic [1:0]          retry_count;
  logic                lockout;

  int n_tests = 0;
  int n_fail  = 0;

  hall_states_t comm_hall [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b110};
  logic [5:0]   comm_pat  [6] = '{6'b100_001, 6'b010_001, 6'b010_100, 6'b001_100, 6'b001_010, 6'b010_001};

  always #500 sys_clk = ~sys_clk;

  bldc_sixstep_driver #(
    .clk_freq_hz     (1_000_000),
    .pwm_freq_hz     (10_000),
    .duty_width      (8),
    .ramp_step       (16),
    .reverse_wait_ms (1),
    .gate_reset_us   (10),
    .fault_retry_max (2)
  ) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .hall_values   (hall_values),
    .invert_phases (invert_phases),
    .enable        (enable),
    .direction     (direction),
    .duty_target   (duty_target),
    .pwm_mode      (pwm_mode),
    .fault_n       (fault_n),
    .clear_lockout (clear_lockout),
    .phase_enable  (phase_enable),
    .pwm_out       (pwm_out),
    .gate_enable   (gate_enable),
    .duty_actual   (duty_actual),
    .driver_state  (driver_state),
    .retry_count   (retry_count),
    .lockout       (lockout)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_duty_change(output int n);
    logic [7:0] prev;
    prev = duty_actual;
    n = 0;
    while (duty_actual == prev && n < 250) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hall_values = 3'b101; invert_phases = 1'b0; enable = 1'b0;
    direction = DIR_FWD; duty_target = 8'd255; pwm_mode = 2'd0; fault_n = 1'b1; clear_lockout = 1'b0;
    tick(3);
    n_tests++;
    if (phase_enable !== 6'd0 || pwm_out !== 6'd0 || gate_enable !== 1'b0 || duty_actual !== 8'd0 ||
        retry_count !== 2'd0 || lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: pe=%b pwm=%b ge=%b duty=%0d retry=%0d lock=%b, want all zero",
               phase_enable, pwm_out, gate_enable, duty_actual, retry_count, lockout);
    end
    n_tests++;
    if (driver_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", driver_state); end
    reset_n = 1'b1;
    tick(3);
    n_tests++;
    if (driver_state !== 3'd0) begin n_fail++; $display("FAIL idle_no_enable: got %0d want 0", driver_state); end
  endtask

  task automatic test_ramp();
    int n, hi_cnt, bad;
    logic [7:0] exp;
    enable = 1'b1;
    tick(1);
    n_tests++;
    if (driver_state !== 3'd1 || gate_enable !== 1'b1 || phase_enable !== 6'b100_010 || duty_actual !== 8'd0) begin
      n_fail++;
      $display("FAIL run_entry: state=%0d ge=%b pe=%b duty=%0d, want 1 1 100010 0",
               driver_state, gate_enable, phase_enable, duty_actual);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'd255 : 8'(16 * (i + 1));
      wait_duty_change(n);
      n_tests++;
      if (duty_actual !== exp) begin n_fail++; $display("FAIL ramp_up[%0d]: got %0d want %0d", i, duty_actual, exp); end
      if (i > 0) begin
        n_tests++;
        if (n != 100) begin n_fail++; $display("FAIL ramp_interval[%0d]: got %0d cycles want 100", i, n); end
      end
    end
    hi_cnt = 0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      hi_cnt += int'(pwm_out[5]);
      if (pwm_out[4:0] !== 5'b00010) bad++;
    end
    n_tests++;
    if (hi_cnt != 100) begin n_fail++; $display("FAIL full_on: high for %0d of 100 want 100", hi_cnt); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL hi_mode_low_static: %0d bad samples want 0", bad); end
  endtask

  task automatic test_pwm_modes();
    int n, c5, c1;
    logic [7:0] exp;
    duty_target = 8'd128;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'd128 : 8'(255 - 16 * (i + 1));
      wait_duty_change(n);
      n_tests++;
      if (duty_actual !== exp) begin n_fail++; $display("FAIL ramp_down[%0d]: got %0d want %0d", i, duty_actual, exp); end
    end
    for (int m = 0; m < 4; m++) begin
      pwm_mode = 2'(m);
      tick(2);
      c5 = 0; c1 = 0;
      for (int k = 0; k < 100; k++) begin
        tick(1);
        c5 += int'(pwm_out[5]);
        c1 += int'(pwm_out[1]);
      end
      n_tests++;
      if (c5 != ((m == 1) ? 100 : 50) || c1 != ((m == 0 || m == 3) ? 100 : 50)) begin
        n_fail++;
        $display("FAIL pwm_mode%0d: hi on %0d lo on %0d of 100, want %0d %0d", m, c5, c1,
                 (m == 1) ? 100 : 50, (m == 0 || m == 3) ? 100 : 50);
      end
    end
    pwm_mode = 2'd0;
  endtask

  task automatic test_commutation();
    logic [5:0] prev;
    prev = 6'b100_010;
    for (int i = 0; i < 6; i++) begin
      hall_values = comm_hall[i];
      tick(2);
      n_tests++;
      if (phase_enable !== prev) begin n_fail++; $display("FAIL comm_early[%0d]: got %b want %b", i, phase_enable, prev); end
      tick(1);
      n_tests++;
      if (phase_enable !== comm_pat[i]) begin n_fail++; $display("FAIL comm[%0d]: got %b want %b", i, phase_enable, comm_pat[i]); end
      prev = comm_pat[i];
    end
    n_tests++;
    if (pwm_out[2:0] !== 3'b001) begin n_fail++; $display("FAIL comm_low_static: got %b want 001", pwm_out[2:0]); end
  endtask

  task automatic test_reverse();
    int n, bad;
    direction = DIR_REV;
    tick(1);
    n_tests++;
    if (driver_state !== 3'd2 || phase_enable !== 6'd0 || gate_enable !== 1'b0 || duty_actual !== 8'd0) begin
      n_fail++;
      $display("FAIL reverse_entry: state=%0d pe=%b ge=%b duty=%0d, want 2 0 0 0",
               driver_state, phase_enable, gate_enable, duty_actual);
    end
    n = 0; bad = 0;
    while (driver_state == 3'd2 && n < 1100) begin
      if (phase_enable !== 6'd0 || pwm_out !== 6'd0 || gate_enable !== 1'b0) bad++;
      if (n == 500) direction = DIR_NONE;
      if (n == 510) direction = DIR_REV;
      tick(1);
      n++;
    end
    n_tests++;
    if (n != 1000) begin n_fail++; $display("FAIL reverse_time: got %0d cycles want 1000", n); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reverse_outputs_off: %0d bad samples want 0", bad); end
    n_tests++;
    if (driver_state !== 3'd1 || phase_enable !== 6'b001_010 || duty_actual !== 8'd0) begin
      n_fail++;
      $display("FAIL reverse_run: state=%0d pe=%b duty=%0d, want 1 001010 0", driver_state, phase_enable, duty_actual);
    end
    invert_phases = 1'b1;
    tick(1);
    n_tests++;
    if (phase_enable !== 6'b010_001) begin n_fail++; $display("FAIL invert_phases: got %b want 010001", phase_enable); end
    invert_phases = 1'b0;
    tick(1);
    wait_duty_change(n);
    n_tests++;
    if (duty_actual !== 8'd16) begin n_fail++; $display("FAIL reverse_ramp: got %0d want 16", duty_actual); end
  endtask

  task automatic test_error();
    hall_values = 3'b111;
    tick(2);
    n_tests++;
    if (driver_state !== 3'd1) begin n_fail++; $display("FAIL error_sync_delay: got %0d want 1", driver_state); end
    tick(1);
    n_tests++;
    if (driver_state !== 3'd3 || phase_enable !== 6'd0 || pwm_out !== 6'd0 || gate_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL error_entry: state=%0d pe=%b pwm=%b ge=%b, want 3 0 0 0", driver_state, phase_enable, pwm_out, gate_enable);
    end
    hall_values = 3'b110;
    tick(3);
    n_tests++;
    if (driver_state !== 3'd0) begin n_fail++; $display("FAIL error_to_idle: got %0d want 0", driver_state); end
    tick(1);
    n_tests++;
    if (driver_state !== 3'd1 || phase_enable !== 6'b001_010) begin
      n_fail++;
      $display("FAIL error_rerun: state=%0d pe=%b want 1 001010", driver_state, phase_enable);
    end
  endtask

  task automatic test_fault();
    int n1, n2, bad;
    fault_n = 1'b0;
    tick(1);
`ifdef BLDC_FAULT_RETRY_EN
    n_tests++;
    if (driver_state !== 3'd4 || retry_count !== 2'd1 || gate_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_reset_entry: state=%0d retry=%0d ge=%b want 4 1 0", driver_state, retry_count, gate_enable);
    end
    n1 = 0; n2 = 0; bad = 0;
    while (driver_state == 3'd4 && retry_count == 2'd1 && n1 < 50) begin
      if (gate_enable !== 1'b0) bad++;
      tick(1); n1++;
    end
    while (driver_state == 3'd4 && retry_count == 2'd2 && n2 < 50) begin
      if (gate_enable !== 1'b0) bad++;
      tick(1); n2++;
    end
    n_tests++;
    if (n1 != 10 || n2 != 10) begin n_fail++; $display("FAIL gate_reset_windows: got %0d and %0d want 10 and 10", n1, n2); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL gate_reset_gate_off: %0d bad samples want 0", bad); end
    n_tests++;
    if (driver_state !== 3'd6 || lockout !== 1'b1 || retry_count !== 2'd2) begin
      n_fail++;
      $display("FAIL lockout_entry: state=%0d lock=%b retry=%0d want 6 1 2", driver_state, lockout, retry_count);
    end
`else
    n1 = 0; n2 = 0; bad = 0;
    n_tests++;
    if (driver_state !== 3'd6 || lockout !== 1'b1 || retry_count !== 2'd0 || gate_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL lockout_direct: state=%0d lock=%b retry=%0d ge=%b want 6 1 0 0",
               driver_state, lockout, retry_count, gate_enable);
    end
    tick(20);
    n_tests++;
    if (driver_state !== 3'd6 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL lockout_hold: state=%0d retry=%0d want 6 0", driver_state, retry_count);
    end
`endif
    n_tests++;
    if (phase_enable !== 6'd0 || pwm_out !== 6'd0) begin
      n_fail++;
      $display("FAIL lockout_outputs: pe=%b pwm=%b want 0 0", phase_enable, pwm_out);
    end
    fault_n = 1'b1;
    clear_lockout = 1'b1;
    tick(1);
    clear_lockout = 1'b0;
    n_tests++;
    if (driver_state !== 3'd0 || retry_count !== 2'd0 || lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_lockout: state=%0d retry=%0d lock=%b want 0 0 0", driver_state, retry_count, lockout);
    end
    tick(1);
    n_tests++;
    if (driver_state !== 3'd1) begin n_fail++; $display("FAIL post_lockout_run: got %0d want 1", driver_state); end
  endtask

  task automatic test_reset_midramp();
    int n;
    duty_target = 8'd255;
    n = 0;
    while (duty_actual < 8'd48 && n < 600) begin
      tick(1);
      n++;
    end
    n_tests++;
    if (duty_actual < 8'd48 || gate_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL midramp_reach: duty=%0d ge=%b want >=48 1", duty_actual, gate_enable);
    end
    #200;
    reset_n = 1'b0;
    #10;
    n_tests++;
    if (phase_enable !== 6'd0 || pwm_out !== 6'd0 || gate_enable !== 1'b0 || duty_actual !== 8'd0 ||
        driver_state !== 3'd0 || lockout !== 1'b0 || retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: pe=%b pwm=%b ge=%b duty=%0d state=%0d lock=%b retry=%0d want all 0",
               phase_enable, pwm_out, gate_enable, duty_actual, driver_state, lockout, retry_count);
    end
    tick(1);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_pwm_modes();
    test_commutation();
    test_reverse();
    test_error();
    test_fault();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
